// File: rtl/fir_capture.sv
// Capture buffer behind a FIR filter: drop the pipeline-fill samples, store DEPTH
// samples with live peak/zero-crossing statistics, then stream them out oldest first.
module fir_capture #(
  parameter int L     = 12,
  parameter int DEPTH = 64,
  parameter int SKIP  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [L-1:0] y,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [L-1:0] rd_data,
  output logic         rd_last,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] peak_max,
  output logic [L-1:0] peak_min,
  output logic [7:0]   zc_count,
  output logic [2:0]   state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [7:0]    SKIP_LAST = 8'((SKIP == 0) ? 0 : SKIP - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    READ    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [7:0]     skip_cnt;
  logic           prev_msb;
  logic           rd_fire;
  logic [L-1:0]   mem [DEPTH];

  // Read port handshake: a word transfers on any rising edge where rd_valid and
  // rd_ready are both high; while rd_valid is high and rd_ready low, rd_data and
  // rd_last hold their values until the transfer happens.
  assign rd_fire = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = (SKIP == 0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (skip_cnt == SKIP_LAST) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (wr_ptr == PTR_LAST) begin
          state_n = READ;
        end
      end
      READ: begin
        if (rd_fire && (rd_ptr == PTR_LAST)) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_valid  = (state == READ);
    rd_data   = rd_valid ? mem[rd_ptr] : '0;
    rd_last   = rd_valid && (rd_ptr == PTR_LAST);
    busy      = (state == SETTLE) || (state == CAPTURE) || (state == READ);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == CAPTURE)) begin
      mem[wr_ptr] <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      peak_max <= '0;
      peak_min <= '0;
      zc_count <= '0;
      prev_msb <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            skip_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
          end
        end
        SETTLE: begin
          skip_cnt <= skip_cnt + 8'd1;
        end
        CAPTURE: begin
          wr_ptr   <= wr_ptr + AW'(1);
          prev_msb <= y[L-1];
          if (wr_ptr == '0) begin
            peak_max <= y;
            peak_min <= y;
            zc_count <= '0;
          end else begin
            if ($signed(y) > $signed(peak_max)) begin
              peak_max <= y;
            end
            if ($signed(y) < $signed(peak_min)) begin
              peak_min <= y;
            end
            // A sign-bit change between consecutive captured samples is one crossing.
            if ((y[L-1] != prev_msb) && (zc_count != 8'hFF)) begin
              zc_count <= zc_count + 8'd1;
            end
          end
        end
        READ: begin
          if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_capture.sv
// Directed bench for fir_capture: drivers push expected words into a queue and a
// negedge monitor pops and checks every read transfer.
module tb_fir_capture;

  localparam int L     = 12;
  localparam int DEPTH = 64;
  localparam int SKIP  = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [L-1:0] y;
  logic         rd_ready;
  logic         rd_valid;
  logic [L-1:0] rd_data;
  logic         rd_last;
  logic         busy;
  logic         done;
  logic [L-1:0] peak_max;
  logic [L-1:0] peak_min;
  logic [7:0]   zc_count;
  logic [2:0]   state_dbg;

  logic [L:0]   exp_q[$];
  int           total;
  int           bad;

  fir_capture #(.L(L), .DEPTH(DEPTH), .SKIP(SKIP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .y        (y),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done),
    .peak_max (peak_max),
    .peak_min (peak_min),
    .zc_count (zc_count),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Input sample presented at the k-th edge after the start edge (start edge is k=0).
  function automatic int pattern(input int mode, input int k);
    case (mode)
      0:       return 100;
      1:       return k;
      default: return (k % 2 == 0) ? 1000 : -1000;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_valid"}, int'(rd_valid), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
    check({tag, "_rd_last"}, int'(rd_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_peak_max"}, int'(peak_max), 0);
    check({tag, "_peak_min"}, int'(peak_min), 0);
    check({tag, "_zc_count"}, int'(zc_count), 0);
    check({tag, "_state"}, int'(state_dbg), 0);
  endtask

  // Scoreboard monitor
  logic         stalled_prev;
  logic [L-1:0] held;
  always @(negedge clk) begin
    logic [L:0]   e;
    logic [L-1:0] ed;
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && rd_valid) begin
        check("stall_hold", int'(rd_data), int'(held));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ed = e[L-1:0];
          check("rd_data", int'($signed(rd_data)), int'($signed(ed)));
          check("rd_last", int'(rd_last), int'(e[L]));
        end
      end
      stalled_prev = rd_valid && !rd_ready;
      held         = rd_data;
    end
  end

  // Driver: one full capture, optionally stalled, optionally cut short by reset.
  task automatic run_capture(input string tag, input int mode, input bit stall, input int rst_at);
    int         k;
    int         v;
    int         mx;
    int         mn;
    int         zc;
    bit         fin;
    bit         hit_rst;
    logic [L-1:0] d;
    mx = 0; mn = 0; zc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = pattern(mode, SKIP + 1 + i);
      d = v[L-1:0];
      exp_q.push_back({(i == DEPTH - 1), d});
      if (i == 0) begin
        mx = v; mn = v;
      end else begin
        if (v > mx) mx = v;
        if (v < mn) mn = v;
        if (((v < 0) != (pattern(mode, SKIP + i) < 0)) && zc < 255) zc++;
      end
    end
    v        = pattern(mode, 0);
    y        = v[L-1:0];
    start    = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, int'(busy), 1);
    k = 1; fin = 0; hit_rst = 0;
    while (!fin && k < 400) begin
      v        = pattern(mode, k);
      y        = v[L-1:0];
      rd_ready = stall ? !((k % 4 == 1) || (k % 4 == 2)) : 1'b1;
      start    = (k == 40) || (k == 100);
      rst      = (k == rst_at);
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0; fin = 1; hit_rst = 1;
        exp_q.delete();
      end else if (done) begin
        fin = 1;
      end
      k++;
    end
    start    = 1'b0;
    rd_ready = 1'b1;
    if (hit_rst) begin
      check_reset_vals({tag, "_after_rst"});
    end else if (!fin) begin
      check({tag, "_done_timeout"}, 0, 1);
      exp_q.delete();
    end else begin
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_busy_in_done"}, int'(busy), 0);
      check({tag, "_rd_valid_in_done"}, int'(rd_valid), 0);
      check({tag, "_words_left"}, exp_q.size(), 0);
      check({tag, "_peak_max"}, int'($signed(peak_max)), mx);
      check({tag, "_peak_min"}, int'($signed(peak_min)), mn);
      check({tag, "_zc_count"}, int'(zc_count), zc);
      @(posedge clk); #1;
      check({tag, "_peak_max_held"}, int'($signed(peak_max)), mx);
      check({tag, "_done_held"}, int'(done), 1);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; y = '0; rd_ready = 1'b1;
    stalled_prev = 1'b0; held = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Constant input, start pulses at k=40 (capture) and k=100 (read) are ignored.
    run_capture("const", 0, 1'b0, -1);
    // Ramp started from DONE; values fixed by the pipeline-fill offset.
    run_capture("ramp", 1, 1'b0, -1);
    run_capture("alt", 2, 1'b0, -1);
    run_capture("stall", 1, 1'b1, -1);
    // Reset 20 cycles into capture (capture begins at k=9).
    run_capture("rst_mid", 1, 1'b0, 29);
    @(posedge clk); #1;
    check("rst_hold_busy", int'(busy), 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_vs_start_busy", int'(busy), 0);
    check("rst_vs_start_state", int'(state_dbg), 0);
    @(posedge clk); #1;
    check("rst_vs_start_idle", int'(busy), 0);

    run_capture("clean", 1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
